// File: rtl/ripple_sum_accumulator.sv
// Accumulates COUNT ripple-carry adder results {carry, sum} into one frame total.
// The total and a sticky overflow flag are presented on a valid/ready handshake.
module ripple_sum_accumulator #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 8,
  parameter int COUNT     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_sum,
  input  logic                 in_carry,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic                 out_ovf,
  output logic                 busy
);

  localparam int CNT_W = $clog2(COUNT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_p0, state_nxt;
  logic [ACC_WIDTH-1:0] acc_p0, acc_nxt;
  logic                 ovf_p0, ovf_nxt;
  logic [CNT_W-1:0]     cnt_p0, cnt_nxt;
  logic [ACC_WIDTH:0]   sum_ext;

  // Bit ACC_WIDTH of the result is the carry out of the accumulator MSB.
  function automatic logic [ACC_WIDTH:0] acc_add(
    input logic [ACC_WIDTH-1:0] a,
    input logic                 c,
    input logic [WIDTH-1:0]     s
  );
    logic [ACC_WIDTH:0] v;
    v          = '0;
    v[WIDTH:0] = {c, s};
    return {1'b0, a} + v;
  endfunction

  always_comb begin
    state_nxt = state_p0;
    acc_nxt   = acc_p0;
    ovf_nxt   = ovf_p0;
    cnt_nxt   = cnt_p0;
    sum_ext   = acc_add(acc_p0, in_carry, in_sum);

    case (state_p0)
      IDLE: begin
        if (start) begin
          state_nxt = ACCUM;
          acc_nxt   = '0;
          ovf_nxt   = 1'b0;
          cnt_nxt   = '0;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_nxt = sum_ext[ACC_WIDTH-1:0];
          ovf_nxt = ovf_p0 | sum_ext[ACC_WIDTH];
          cnt_nxt = cnt_p0 + CNT_W'(1);
          if (cnt_p0 == CNT_W'(COUNT - 1)) state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Abort overrides every other transition, including the output handshake.
    if (clear) begin
      state_nxt = IDLE;
      acc_nxt   = '0;
      ovf_nxt   = 1'b0;
      cnt_nxt   = '0;
    end
  end

  // Stage p0: state, accumulator, overflow and beat count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      acc_p0   <= '0;
      ovf_p0   <= 1'b0;
      cnt_p0   <= '0;
    end else begin
      state_p0 <= state_nxt;
      acc_p0   <= acc_nxt;
      ovf_p0   <= ovf_nxt;
      cnt_p0   <= cnt_nxt;
    end
  end

  assign in_ready  = (state_p0 == ACCUM);
  assign out_valid = (state_p0 == DONE);
  assign busy      = (state_p0 != IDLE);
  assign out_acc   = acc_p0;
  assign out_ovf   = ovf_p0;

endmodule

// File: tb/tb_ripple_sum_accumulator.sv
// Randomized bench for ripple_sum_accumulator; expected totals come from plain
// integer summation of each frame's beat values.
module tb_ripple_sum_accumulator;

  localparam int WIDTH     = 4;
  localparam int ACC_WIDTH = 8;
  localparam int COUNT     = 16;

  typedef logic [WIDTH:0] beat_t;
  typedef beat_t frame_t [COUNT];

  logic                 clk, rst_n, start, clear, in_valid, in_ready, in_carry;
  logic                 out_valid, out_ready, out_ovf, busy;
  logic [WIDTH-1:0]     in_sum;
  logic [ACC_WIDTH-1:0] out_acc;

  int n_checks = 0;
  int n_fail   = 0;

  ripple_sum_accumulator #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH), .COUNT(COUNT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
    .out_ovf(out_ovf), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_total(input frame_t f);
    int t;
    t = 0;
    foreach (f[i]) t += int'(f[i]);
    return t;
  endfunction

  function automatic frame_t rand_frame();
    frame_t f;
    foreach (f[i]) f[i] = beat_t'($urandom);
    return f;
  endfunction

  function automatic frame_t const_frame(input int v);
    frame_t f;
    foreach (f[i]) f[i] = beat_t'(v);
    return f;
  endfunction

  // Starts a frame and feeds COUNT beats; reports whether in_ready stayed high
  // and out_valid stayed low until the last beat was accepted.
  task automatic drive_frame(input frame_t f, input bit gaps,
                             output bit rdy_ok, output bit early_ok);
    int i, cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    rdy_ok = 1'b1; early_ok = 1'b1; i = 0; cyc = 0;
    while (i < COUNT) begin
      if (in_ready !== 1'b1) rdy_ok = 1'b0;
      if (out_valid !== 1'b0) early_ok = 1'b0;
      if (gaps && (cyc % 2 == 1)) begin
        in_valid = 1'b0;
        {in_carry, in_sum} = beat_t'($urandom);
      end else begin
        in_valid = 1'b1;
        {in_carry, in_sum} = f[i];
        i++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (out_acc !== '0) begin n_fail++; $display("FAIL reset_out_acc: got %0d expected 0", out_acc); end
    n_checks++; if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_out_ovf: got %b expected 0", out_ovf); end
    step(); step();
    rst_n = 1'b1;
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_fixed_patterns();
    int vals [3]  = '{5, 31, 23};
    bit gaps [3]  = '{1'b0, 1'b0, 1'b1};
    int exp_a [3] = '{80, 240, 112};
    bit exp_o [3] = '{1'b0, 1'b1, 1'b1};
    bit rdy_ok, early_ok;
    for (int k = 0; k < 3; k++) begin
      drive_frame(const_frame(vals[k]), gaps[k], rdy_ok, early_ok);
      n_checks++; if (!rdy_ok) begin n_fail++; $display("FAIL fixed%0d_in_ready: dropped before last beat, expected 1", k); end
      n_checks++; if (!early_ok) begin n_fail++; $display("FAIL fixed%0d_early_valid: out_valid before last beat, expected 0", k); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fixed%0d_out_valid: got %b expected 1", k, out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fixed%0d_done_in_ready: got %b expected 0", k, in_ready); end
      n_checks++; if (out_acc !== ACC_WIDTH'(exp_a[k])) begin n_fail++; $display("FAIL fixed%0d_acc: got %0d expected %0d", k, out_acc, exp_a[k]); end
      n_checks++; if (out_ovf !== exp_o[k]) begin n_fail++; $display("FAIL fixed%0d_ovf: got %b expected %b", k, out_ovf, exp_o[k]); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL fixed%0d_release: out_valid=%b busy=%b expected 0 0", k, out_valid, busy); end
    end
  endtask

  task automatic test_random_frames();
    frame_t f;
    int t;
    bit rdy_ok, early_ok, g;
    for (int k = 0; k < 6; k++) begin
      f = rand_frame();
      g = 1'($urandom_range(0, 1));
      t = model_total(f);
      drive_frame(f, g, rdy_ok, early_ok);
      n_checks++; if (!rdy_ok || !early_ok) begin n_fail++; $display("FAIL rand%0d_handshake: rdy_ok=%b early_ok=%b expected 1 1", k, rdy_ok, early_ok); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rand%0d_out_valid: got %b expected 1", k, out_valid); end
      n_checks++; if (out_acc !== ACC_WIDTH'(t % (1 << ACC_WIDTH))) begin n_fail++; $display("FAIL rand%0d_acc: got %0d expected %0d", k, out_acc, t % (1 << ACC_WIDTH)); end
      n_checks++; if (out_ovf !== (t >= (1 << ACC_WIDTH))) begin n_fail++; $display("FAIL rand%0d_ovf: got %b expected %b", k, out_ovf, t >= (1 << ACC_WIDTH)); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand%0d_release_busy: got %b expected 0", k, busy); end
    end
  endtask

  task automatic test_done_hold();
    frame_t f;
    int t;
    bit rdy_ok, early_ok;
    logic [ACC_WIDTH-1:0] ea;
    logic eo;
    f = rand_frame();
    t = model_total(f);
    ea = ACC_WIDTH'(t % (1 << ACC_WIDTH));
    eo = (t >= (1 << ACC_WIDTH));
    drive_frame(f, 1'b0, rdy_ok, early_ok);
    for (int c = 0; c < 5; c++) begin
      out_ready = 1'b0;
      in_valid = 1'b1;
      {in_carry, in_sum} = beat_t'($urandom);
      start = (c % 2 == 0);
      step();
      n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL hold%0d_ctrl: out_valid=%b in_ready=%b expected 1 0", c, out_valid, in_ready); end
      n_checks++; if (out_acc !== ea || out_ovf !== eo) begin n_fail++; $display("FAIL hold%0d_data: acc=%0d ovf=%b expected %0d %b", c, out_acc, out_ovf, ea, eo); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    step();
    out_ready = 1'b0;
    start = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL hold_release: out_valid=%b busy=%b expected 0 0", out_valid, busy); end
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hold_start_ignored: busy=%b expected 0", busy); end
  endtask

  task automatic test_clear();
    frame_t f;
    int t;
    bit rdy_ok, early_ok;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      {in_carry, in_sum} = beat_t'($urandom_range(1, 31));
      step();
    end
    clear = 1'b1; in_valid = 1'b1; start = 1'b1;
    step();
    clear = 1'b0; in_valid = 1'b0; start = 1'b0;
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_accum_ctrl: busy=%b in_ready=%b out_valid=%b expected 0 0 0", busy, in_ready, out_valid); end
    n_checks++; if (out_acc !== '0 || out_ovf !== 1'b0) begin n_fail++; $display("FAIL clear_accum_data: acc=%0d ovf=%b expected 0 0", out_acc, out_ovf); end
    drive_frame(const_frame(31), 1'b0, rdy_ok, early_ok);
    clear = 1'b1; out_ready = 1'b1;
    step();
    clear = 1'b0; out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL clear_done_ctrl: out_valid=%b busy=%b expected 0 0", out_valid, busy); end
    n_checks++; if (out_acc !== '0 || out_ovf !== 1'b0) begin n_fail++; $display("FAIL clear_done_data: acc=%0d ovf=%b expected 0 0", out_acc, out_ovf); end
    f = rand_frame();
    t = model_total(f);
    drive_frame(f, 1'b0, rdy_ok, early_ok);
    n_checks++; if (out_valid !== 1'b1 || out_acc !== ACC_WIDTH'(t % (1 << ACC_WIDTH))) begin n_fail++; $display("FAIL clear_fresh_frame: valid=%b acc=%0d expected 1 %0d", out_valid, out_acc, t % (1 << ACC_WIDTH)); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    bit rdy_ok, early_ok;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      {in_carry, in_sum} = beat_t'($urandom_range(1, 31));
      step();
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_ctrl: busy=%b in_ready=%b out_valid=%b expected 0 0 0", busy, in_ready, out_valid); end
    n_checks++; if (out_acc !== '0 || out_ovf !== 1'b0) begin n_fail++; $display("FAIL areset_data: acc=%0d ovf=%b expected 0 0", out_acc, out_ovf); end
    in_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    drive_frame(const_frame(1), 1'b0, rdy_ok, early_ok);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_frame_valid: got %b expected 1", out_valid); end
    n_checks++; if (out_acc !== ACC_WIDTH'(16) || out_ovf !== 1'b0) begin n_fail++; $display("FAIL areset_frame_data: acc=%0d ovf=%b expected 16 0", out_acc, out_ovf); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; clear = 1'b0; in_valid = 1'b0;
    in_sum = '0; in_carry = 1'b0; out_ready = 1'b0;
    test_reset();
    test_fixed_patterns();
    test_random_frames();
    test_done_hold();
    test_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
